ex_muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide engine for the EX stage. Executes MULT/MULTU/DIV/DIVU (result to HI/LO)
//  and MUL (low product to GPR), asserts a stall request while busy, and presents the result to the
//  EX->MEM bus. It is parametrised in operand width and multiplier pipeline depth, and supports flush.

---
 rtl/ex_muldiv_unit_pkg.sv | 27 ++
 rtl/ex_muldiv_unit_if.sv | 30 +++
 rtl/div_radix2_iter.sv | 75 +++++++
 rtl/ex_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared op encodings, FSM state type and small decode helpers for the EX-stage mul/div unit.
package ex_muldiv_unit_pkg;

  localparam int MD_OP_WD = 3;

  localparam logic [MD_OP_WD-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_WD-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_WD-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_WD-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_WD-1:0] MD_MUL   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [MD_OP_WD-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [MD_OP_WD-1:0] op);
    return (op == MD_MULT) || (op == MD_MUL) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX <-> mul/div unit bus: operation request from EX, stall request and result back to EX/MEM.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);

  // Handshake: EX holds op_valid/op/src1/src2 steady while stallreq is high; the unit samples the
  // operands once on the accept edge. res_valid marks a result for the EX->MEM bus; it is held
  // (outputs stable) while pipe_stall is high and retires on the first edge with pipe_stall low.
  logic                                      op_valid;
  logic [ex_muldiv_unit_pkg::MD_OP_WD-1:0]   op;
  logic [WIDTH-1:0]                          src1;
  logic [WIDTH-1:0]                          src2;
  logic                                      flush;
  logic                                      pipe_stall;
  logic                                      stallreq;
  logic                                      res_valid;
  logic                                      hi_we;
  logic                                      lo_we;
  logic [WIDTH-1:0]                          hi_o;
  logic [WIDTH-1:0]                          lo_o;

  modport master (
    output op_valid, op, src1, src2, flush, pipe_stall,
    input  stallreq, res_valid, hi_we, lo_we, hi_o, lo_o
  );

  modport slave (
    input  op_valid, op, src1, src2, flush, pipe_stall,
    output stallreq, res_valid, hi_we, lo_we, hi_o, lo_o
  );

endinterface

// File: rtl/div_radix2_iter.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle after start,
// with sign fix-up applied to the quotient/remainder outputs.
module div_radix2_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

    logic              busy;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  d;
    logic              neg_q;
    logic              neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    // Partial remainder shifted left by one with the next dividend bit; diff[WIDTH] is the borrow.
    assign shifted = {rem, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            step  <= '0;
            q     <= '0;
            rem   <= '0;
            d     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            step  <= '0;
            q     <= a_mag;
            rem   <= '0;
            d     <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (busy) begin
            q    <= {q[WIDTH-2:0], ~diff[WIDTH]};
            rem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            step <= step + 1'b1;
            if (step == STEP_LAST) begin
                busy <= 1'b0;
            end
        end
    end

    assign done      = busy && (step == STEP_LAST);
    assign quotient  = neg_q ? (~q + 1'b1) : q;
    assign remainder = neg_r ? (~rem + 1'b1) : rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage: MULT/MULTU/DIV/DIVU to HI/LO, MUL to GPR.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_muldiv_unit_if.slave      bus,
    output md_state_e            dbg_state
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int PIPE_N = (MUL_STAGES > 1) ? (MUL_STAGES - 1) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);

    md_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic [MD_OP_WD-1:0]   op_r;
    logic [WIDTH-1:0]      res_hi;
    logic [WIDTH-1:0]      res_lo;
    logic                  res_from_div;

    logic                  accept;
    logic                  op_signed;
    logic [2*WIDTH-1:0]    mul_a;
    logic [2*WIDTH-1:0]    mul_b;
    logic [2*WIDTH-1:0]    mul_full;
    logic [2*WIDTH-1:0]    mul_tail;
    logic [2*WIDTH-1:0]    mul_pipe [PIPE_N];

    logic                  div_start;
    logic                  div_done;
    logic [WIDTH-1:0]      div_q;
    logic [WIDTH-1:0]      div_r;

    assign accept    = (state == ST_IDLE) && bus.op_valid && !bus.flush;
    assign op_signed = md_is_signed(bus.op);

    // Extending to 2*WIDTH first makes one unsigned multiply serve both signed and unsigned forms.
    assign mul_a    = {{WIDTH{op_signed & bus.src1[WIDTH-1]}}, bus.src1};
    assign mul_b    = {{WIDTH{op_signed & bus.src2[WIDTH-1]}}, bus.src2};
    assign mul_full = mul_a * mul_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_N; k++) begin
                mul_pipe[k] <= '0;
            end
        end else begin
            mul_pipe[0] <= mul_full;
            for (int k = 1; k < PIPE_N; k++) begin
                mul_pipe[k] <= mul_pipe[k-1];
            end
        end
    end

    assign mul_tail = (MUL_STAGES > 1) ? mul_pipe[PIPE_N-1] : mul_full;

    assign div_start = accept && md_is_div(bus.op) && (bus.src2 != '0);

    div_radix2_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (bus.op == MD_DIV),
        .dividend  (bus.src1),
        .divisor   (bus.src2),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_r         <= MD_MULT;
            res_hi       <= '0;
            res_lo       <= '0;
            res_from_div <= 1'b0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        op_r <= bus.op;
                        cnt  <= '0;
                        if (md_is_div(bus.op)) begin
                            if (bus.src2 == '0) begin
                                state        <= ST_DONE;
                                res_hi       <= bus.src1;
                                res_lo       <= '1;
                                res_from_div <= 1'b0;
                            end else begin
                                state        <= ST_DIV;
                                res_from_div <= 1'b1;
                            end
                        end else if (MUL_STAGES == 1) begin
                            state            <= ST_DONE;
                            {res_hi, res_lo} <= mul_tail;
                            res_from_div     <= 1'b0;
                        end else begin
                            state        <= ST_MUL;
                            cnt          <= CNT_W'(1);
                            res_from_div <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt == MUL_LAST) begin
                        state            <= ST_DONE;
                        {res_hi, res_lo} <= mul_tail;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (div_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.pipe_stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stallreq  = accept || (state == ST_MUL) || (state == ST_DIV);
    assign bus.res_valid = (state == ST_DONE);
    assign bus.hi_we     = bus.res_valid && (op_r != MD_MUL);
    assign bus.lo_we     = bus.hi_we;
    // Divider registers stop iterating once done, so they hold the result steady through DONE.
    assign bus.hi_o      = !bus.res_valid ? '0 : (res_from_div ? div_r : res_hi);
    assign bus.lo_o      = !bus.res_valid ? '0 : (res_from_div ? div_q : res_lo);
    assign dbg_state     = state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed corner cases plus random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int MS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  md_state_e dbg_state;

  ex_muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation's meaning; returns expected latency.
  function automatic int ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint    sp;
    logic [63:0] up;
    int        sa;
    int        sb;
    sa = int'(a);
    sb = int'(b);
    hi = '0;
    lo = '0;
    if (op == MD_MULT || op == MD_MUL) begin
      sp = longint'(sa) * longint'(sb);
      {hi, lo} = sp;
      return MS;
    end else if (op == MD_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      {hi, lo} = up;
      return MS;
    end else if (b == 0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      return 1;
    end else if (op == MD_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 0;
      end else begin
        lo = sa / sb;
        hi = sa % sb;
      end
      return W + 1;
    end else begin
      lo = a / b;
      hi = a % b;
      return W + 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge with the unit idle; returns just after the retiring edge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int nstall);
    logic [W-1:0]   eh;
    logic [W-1:0]   el;
    logic [2*W-1:0] e;
    int lat;
    int edges;
    int stalls;
    lat = ref_model(op, a, b, eh, el);
    exp_q.push_back({eh, el});
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    #1;
    stalls = bus.stallreq ? 1 : 0;
    edges  = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      bus.src1 = $urandom;
      bus.src2 = $urandom;
      if (bus.res_valid) break;
      if (bus.stallreq) stalls++;
    end
    e = exp_q.pop_front();
    check_val("latency", 64'(edges), 64'(lat));
    check_val("stall_cycles", 64'(stalls), 64'(lat));
    check_val("hi", bus.hi_o, e[2*W-1:W]);
    check_val("lo", bus.lo_o, e[W-1:0]);
    check_val("hi_we", bus.hi_we, op != MD_MUL);
    check_val("lo_we", bus.lo_we, op != MD_MUL);
    check_val("stallreq_done", bus.stallreq, 1'b0);
    for (int s = 0; s < nstall; s++) begin
      bus.pipe_stall = 1'b1;
      @(posedge clk);
      #1;
      check_val("hold_valid", bus.res_valid, 1'b1);
      check_val("hold_hi", bus.hi_o, e[2*W-1:W]);
      check_val("hold_lo", bus.lo_o, e[W-1:0]);
      check_val("hold_we", bus.hi_we, op != MD_MUL);
    end
    bus.pipe_stall = 1'b0;
    @(posedge clk);
    #1;
    check_val("retire_state", dbg_state, ST_IDLE);
    check_val("retire_valid", bus.res_valid, 1'b0);
    bus.op_valid = 1'b0;
  endtask

  task automatic flush_div(input logic [W-1:0] a, input logic [W-1:0] b, input int iter);
    int seen;
    bus.op_valid = 1'b1;
    bus.op       = MD_DIV;
    bus.src1     = a;
    bus.src2     = b;
    @(posedge clk);
    #1;
    repeat (iter - 1) @(posedge clk);
    #1;
    check_val("flush_pre_state", dbg_state, ST_DIV);
    bus.flush    = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check_val("flush_state", dbg_state, ST_IDLE);
    check_val("flush_valid", bus.res_valid, 1'b0);
    check_val("flush_hi_we", bus.hi_we, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.res_valid || bus.hi_we) seen++;
    end
    check_val("flush_no_result", 64'(seen), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] rop;
    bus.op_valid   = 1'b0;
    bus.op         = MD_MULT;
    bus.src1       = '0;
    bus.src2       = '0;
    bus.flush      = 1'b0;
    bus.pipe_stall = 1'b0;
    #2;
    check_val("rst_state", dbg_state, ST_IDLE);
    check_val("rst_valid", bus.res_valid, 1'b0);
    check_val("rst_hi_we", bus.hi_we, 1'b0);
    check_val("rst_hi", bus.hi_o, 32'd0);
    check_val("rst_lo", bus.lo_o, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_op(MD_DIVU,  32'd100, 32'd7, 2);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_DIVU,  32'd5, 32'd0, 0);
    run_op(MD_MUL,   32'd6, 32'd7, 0);
    flush_div(32'd1000, 32'd3, 10);
    run_op(MD_DIV,   32'hFFFF_FC18, 32'd7, 0);
    run_op(MD_MULT,  32'd12345, 32'hFFFF_FF00, 3);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 4));
      run_op(rop, rand_opnd(), rand_opnd(), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a multiply.
    bus.op_valid = 1'b1;
    bus.op       = MD_MULT;
    bus.src1     = 32'd9;
    bus.src2     = 32'd9;
    @(posedge clk);
    #1;
    check_val("mid_mul_state", dbg_state, ST_MUL);
    bus.op_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("arst_state", dbg_state, ST_IDLE);
    check_val("arst_valid", bus.res_valid, 1'b0);
    check_val("arst_stallreq", bus.stallreq, 1'b0);
    check_val("arst_hi", bus.hi_o, 32'd0);
    check_val("arst_lo", bus.lo_o, 32'd0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(MD_MULTU, 32'd7, 32'd8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
